// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for one DMEM arbiter port: request fields plus grant/response.
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the single-ported DMEM with 1-cycle response routing.
module dmem_arbiter #(
    parameter  int unsigned MEM_WORDS = 4096,
    localparam int unsigned AW        = $clog2(MEM_WORDS)
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_arbiter_if.slave        p0,
    dmem_arbiter_if.slave        p1,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_wstrb,
    input  logic [31:0]          mem_rdata
);

    typedef struct packed {
        logic valid;
        logic port;
        logic is_read;
        logic err;
    } rsp_t;

    rsp_t        rsp_q;
    logic        last_grant_q;
    logic        any_req;
    logic        sel_p1;
    logic        win_we;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic [3:0]  win_wstrb;
    logic        in_range;
    logic        rsp_live;
    logic [31:0] rsp_data;
    logic        unused_addr_lsb;

    // Pick the winner: sole requester, else the port not granted most recently
    always_comb begin
        any_req = !reset && (p0.req || p1.req);
        if (p0.req && p1.req) begin
            sel_p1 = !last_grant_q;
        end else begin
            sel_p1 = p1.req;
        end
        win_we    = sel_p1 ? p1.we    : p0.we;
        win_addr  = sel_p1 ? p1.addr  : p0.addr;
        win_wdata = sel_p1 ? p1.wdata : p0.wdata;
        win_wstrb = sel_p1 ? p1.wstrb : p0.wstrb;
        in_range  = (win_addr[31:AW+2] == '0);
    end

    assign unused_addr_lsb = ^win_addr[1:0];

    // Grants and memory port; out-of-range grants never touch the array
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        p0.gnt    = any_req && !sel_p1;
        p1.gnt    = any_req && sel_p1;
        if (any_req && in_range) begin
            mem_en    = 1'b1;
            mem_we    = win_we;
            mem_addr  = win_addr[AW+1:2];
            mem_wdata = win_wdata;
            mem_wstrb = win_wstrb;
        end
    end

    // Round-robin history and the single-entry response register
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            rsp_q        <= '0;
        end else begin
            if (any_req) begin
                last_grant_q <= sel_p1;
            end
            rsp_q.valid   <= any_req;
            rsp_q.port    <= sel_p1;
            rsp_q.is_read <= !win_we;
            rsp_q.err     <= !in_range;
        end
    end

    // Route the response to its owner; reset suppresses an in-flight response
    always_comb begin
        rsp_live  = rsp_q.valid && !reset;
        rsp_data  = (rsp_q.is_read && !rsp_q.err) ? mem_rdata : 32'h0;
        p0.rvalid = rsp_live && !rsp_q.port;
        p0.err    = rsp_live && !rsp_q.port && rsp_q.err;
        p0.rdata  = (rsp_live && !rsp_q.port) ? rsp_data : 32'h0;
        p1.rvalid = rsp_live && rsp_q.port;
        p1.err    = rsp_live && rsp_q.port && rsp_q.err;
        p1.rdata  = (rsp_live && rsp_q.port) ? rsp_data : 32'h0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed test-plan steps then randomized traffic against a reference model.
module tb_dmem_arbiter;
    localparam int unsigned MEM_WORDS = 4096;
    localparam int unsigned AW        = 12;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } rq_t;

    logic          clk;
    logic          reset;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic [31:0]   mem_rdata;

    dmem_arbiter_if p0_if ();
    dmem_arbiter_if p1_if ();

    dmem_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .p0        (p0_if),
        .p1        (p1_if),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory array behind the arbiter: byte-masked write, registered read
    logic [31:0] mem [0:MEM_WORDS-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [0:MEM_WORDS-1];
    int          ref_last;
    logic        pend_v;
    int          pend_port;
    logic        pend_err;
    logic [31:0] pend_data;
    logic        g0, g1;

    int checks;
    int failures;
    rq_t rq0, rq1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        checks++;
        assert (obs === expd) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expd);
        end
    endtask

    function automatic rq_t idle();
        return '0;
    endfunction

    function automatic rq_t ld(input logic [31:0] a);
        rq_t q;
        q      = '0;
        q.req  = 1'b1;
        q.addr = a;
        return q;
    endfunction

    function automatic rq_t st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        rq_t q;
        q.req   = 1'b1;
        q.we    = 1'b1;
        q.addr  = a;
        q.wdata = d;
        q.wstrb = s;
        return q;
    endfunction

    function automatic rq_t rnd_req();
        rq_t q;
        q.req   = ($urandom_range(0, 3) != 0);
        q.we    = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) q.addr = $urandom | 32'h0000_4000;
        else                            q.addr = 32'($urandom_range(0, 63));
        q.wdata = $urandom;
        q.wstrb = 4'($urandom_range(0, 15));
        return q;
    endfunction

    // One clock cycle: drive, check mid-cycle against the model, advance the model
    task automatic cycle(input logic rst, input rq_t q0, input rq_t q1);
        int          win;
        rq_t         w;
        logic        ok;
        logic        ev;
        logic [31:0] idx;
        logic [31:0] mask;
        reset       = rst;
        p0_if.req   = q0.req;   p0_if.we = q0.we;   p0_if.addr = q0.addr;
        p0_if.wdata = q0.wdata; p0_if.wstrb = q0.wstrb;
        p1_if.req   = q1.req;   p1_if.we = q1.we;   p1_if.addr = q1.addr;
        p1_if.wdata = q1.wdata; p1_if.wstrb = q1.wstrb;
        #4;
        win = -1;
        if (!rst) begin
            if (q0.req && q1.req) win = 1 - ref_last;
            else if (q0.req)      win = 0;
            else if (q1.req)      win = 1;
        end
        w   = (win == 1) ? q1 : q0;
        idx = w.addr >> 2;
        ok  = (win >= 0) && (idx < MEM_WORDS);
        ev  = pend_v && !rst;
        check("gnt",       32'({p0_if.gnt, p1_if.gnt}), 32'({win == 0, win == 1}));
        check("mem_ctl",   32'({mem_en, mem_we}),       32'({ok, ok && w.we}));
        check("mem_addr",  32'(mem_addr),               ok ? idx : 32'h0);
        check("mem_wdata", mem_wdata,                   ok ? w.wdata : 32'h0);
        check("mem_wstrb", 32'(mem_wstrb),              ok ? 32'(w.wstrb) : 32'h0);
        check("p0_resp",   32'({p0_if.rvalid, p0_if.err}),
              32'({ev && pend_port == 0, ev && pend_port == 0 && pend_err}));
        check("p0_rdata",  p0_if.rdata, (ev && pend_port == 0) ? pend_data : 32'h0);
        check("p1_resp",   32'({p1_if.rvalid, p1_if.err}),
              32'({ev && pend_port == 1, ev && pend_port == 1 && pend_err}));
        check("p1_rdata",  p1_if.rdata, (ev && pend_port == 1) ? pend_data : 32'h0);
        if (rst) begin
            pend_v   = 1'b0;
            ref_last = 1;
        end else begin
            pend_v    = (win >= 0);
            pend_port = win;
            pend_err  = !ok;
            pend_data = 32'h0;
            if (ok && !w.we) pend_data = ref_mem[idx];
            if (ok && w.we) begin
                mask = {{8{w.wstrb[3]}}, {8{w.wstrb[2]}}, {8{w.wstrb[1]}}, {8{w.wstrb[0]}}};
                ref_mem[idx] = (ref_mem[idx] & ~mask) | (w.wdata & mask);
            end
            if (win >= 0) ref_last = win;
        end
        g0 = (win == 0);
        g1 = (win == 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ref_last = 1;
        pend_v   = 1'b0;
        pend_port = 0;
        pend_err = 1'b0;
        pend_data = 32'h0;
        g0 = 1'b0;
        g1 = 1'b0;
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        cycle(1'b1, idle(), idle());
        cycle(1'b1, idle(), idle());

        // Store then load of the same word
        cycle(1'b0, st(32'h10, 32'hDEAD_BEEF, 4'hF), idle());
        cycle(1'b0, idle(), idle());
        cycle(1'b0, ld(32'h10), idle());
        check("tp_load_valid", 32'(p0_if.rvalid), 32'h1);
        check("tp_load_data",  p0_if.rdata, 32'hDEAD_BEEF);
        cycle(1'b0, idle(), idle());

        // Byte-lane store over an existing word (lane-aligned data for byte 3)
        cycle(1'b0, st(32'h10, 32'h1122_3344, 4'hF), idle());
        cycle(1'b0, idle(), st(32'h13, 32'hAA00_0000, 4'h8));
        cycle(1'b0, ld(32'h10), idle());
        check("tp_byte_store", p0_if.rdata, 32'hAA22_3344);

        // Continuous contention after reset alternates starting with p0
        cycle(1'b1, idle(), idle());
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, ld(32'($urandom_range(0, 63))), ld(32'($urandom_range(0, 63))));
            check("rr_seq", 32'(g1), 32'(i % 2));
        end
        cycle(1'b0, idle(), idle());

        // Out-of-range load
        cycle(1'b0, ld(32'h4000), idle());
        check("tp_oor", 32'({p0_if.rvalid, p0_if.err}), 32'h3);
        check("tp_oor_data", p0_if.rdata, 32'h0);

        // Reset right after a p1 load grant drops its response; p0 wins next contention
        cycle(1'b0, idle(), ld(32'h20));
        cycle(1'b1, idle(), idle());
        cycle(1'b0, ld(32'h30), ld(32'h40));
        check("tp_rst_rr", 32'({g0, g1}), 32'h2);

        // Randomized traffic; a requester not granted holds its request
        rq0 = rnd_req();
        rq1 = rnd_req();
        for (int i = 0; i < 400; i++) begin
            logic r;
            r = ($urandom_range(0, 49) == 0);
            cycle(r, rq0, rq1);
            if (r || g0 || !rq0.req) rq0 = rnd_req();
            if (r || g1 || !rq1.req) rq1 = rnd_req();
        end
        cycle(1'b0, idle(), idle());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
